// File: rtl/cache_cmd_dispatch_if.sv
// Command-in / cache-out / response bundle for the cache command dispatcher.
// The slave modport is the dispatcher's view, and the master modport is its environment's view.
interface cache_cmd_dispatch_if #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int INDEX_W  = 4,
    parameter int OFFSET_W = 2,
    parameter int CNT_W    = 16
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_op;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_data;

    logic                cache_req;
    logic [1:0]          cache_op;
    logic [TAG_W-1:0]    cache_tag;
    logic [INDEX_W-1:0]  cache_index;
    logic [OFFSET_W-1:0] cache_offset;
    logic [DATA_W-1:0]   cache_wdata;
    logic                cache_ack;
    logic [DATA_W-1:0]   cache_rdata;

    logic                rsp_valid;
    logic [DATA_W-1:0]   rsp_data;
    logic [ADDR_W-1:0]   rsp_addr;

    logic [CNT_W-1:0]    rd_count;
    logic [CNT_W-1:0]    wr_count;
    logic [CNT_W-1:0]    fl_count;
    logic [CNT_W-1:0]    nop_count;
    logic                busy;

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, cache_ack, cache_rdata,
        output cmd_ready, cache_req, cache_op, cache_tag, cache_index, cache_offset,
               cache_wdata, rsp_valid, rsp_data, rsp_addr,
               rd_count, wr_count, fl_count, nop_count, busy
    );

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, cache_ack, cache_rdata,
        input  cmd_ready, cache_req, cache_op, cache_tag, cache_index, cache_offset,
               cache_wdata, rsp_valid, rsp_data, rsp_addr,
               rd_count, wr_count, fl_count, nop_count, busy
    );
endinterface

// File: rtl/cache_cmd_dispatch.sv
// Buffers cache commands in a FIFO and issues them one at a time over a req/ack handshake.
// READ data comes back as a one-cycle response, and per-op completion counters are kept.
module cache_cmd_dispatch #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 8,
    parameter int INDEX_W  = 4,
    parameter int OFFSET_W = 2,
    parameter int CNT_W    = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    cache_cmd_dispatch_if.slave bus
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_FLUSH = 2'b11;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t state, state_nx;

    logic [1:0]        fifo_op   [DEPTH];
    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    logic              full, fifo_ne, push, pop, ack_done;
    logic [1:0]        head_op;

    logic [1:0]        iss_op;
    logic [ADDR_W-1:0] iss_addr;
    logic [DATA_W-1:0] iss_data;

    // A full FIFO refuses a push even when a pop happens in the same cycle.
    assign full          = (count == (PTR_W+1)'(DEPTH));
    assign fifo_ne       = (count != '0);
    assign push          = bus.cmd_valid && !full;
    assign head_op       = fifo_op[rd_ptr];
    assign bus.cmd_ready = !full;
    assign bus.busy      = fifo_ne || (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op[wr_ptr]   <= bus.cmd_op;
            fifo_addr[wr_ptr] <= bus.cmd_addr;
            fifo_data[wr_ptr] <= bus.cmd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (fifo_ne && head_op != OP_NOP) state_nx = ISSUE;
            ISSUE:   if (bus.cache_ack) state_nx = (iss_op == OP_READ) ? RESP : IDLE;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        pop           = 1'b0;
        ack_done      = 1'b0;
        bus.cache_req = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state)
            IDLE:    pop = fifo_ne;
            ISSUE: begin
                bus.cache_req = 1'b1;
                ack_done      = bus.cache_ack;
            end
            RESP:    bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Issue registers hold the cache fields steady until the next non-NOP pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_op        <= '0;
            iss_addr      <= '0;
            iss_data      <= '0;
            bus.rsp_data  <= '0;
            bus.rsp_addr  <= '0;
            bus.rd_count  <= '0;
            bus.wr_count  <= '0;
            bus.fl_count  <= '0;
            bus.nop_count <= '0;
        end else begin
            if (pop && head_op == OP_NOP)
                bus.nop_count <= bus.nop_count + CNT_W'(1);
            if (pop && head_op != OP_NOP) begin
                iss_op   <= head_op;
                iss_addr <= fifo_addr[rd_ptr];
                iss_data <= fifo_data[rd_ptr];
            end
            if (ack_done) begin
                case (iss_op)
                    OP_READ: begin
                        bus.rsp_data <= bus.cache_rdata;
                        bus.rsp_addr <= iss_addr;
                        bus.rd_count <= bus.rd_count + CNT_W'(1);
                    end
                    OP_WRITE: bus.wr_count <= bus.wr_count + CNT_W'(1);
                    OP_FLUSH: bus.fl_count <= bus.fl_count + CNT_W'(1);
                    default:  ;
                endcase
            end
        end
    end

    assign bus.cache_op     = iss_op;
    assign bus.cache_tag    = iss_addr[ADDR_W-1 -: TAG_W];
    assign bus.cache_index  = iss_addr[INDEX_W+OFFSET_W-1 -: INDEX_W];
    assign bus.cache_offset = iss_addr[OFFSET_W-1:0];
    assign bus.cache_wdata  = iss_data;
endmodule

// File: doc/cache_cmd_dispatch.md
Name: cache_cmd_dispatch

Overview:
- Downstream consumer of the command stream read from commands.txt; issues each command to the set-associative cache.
- Input command fields: 2-bit op (Cbits), 12-bit address (word), 32-bit data (dataval).
- Buffers commands in a small FIFO, decodes op and splits the address into tag/index/offset.
- Drives a req/ack handshake into the cache, returns read data on a response port and keeps per-op counters.

Parameters:
ADDR_W, 12, command address width
DATA_W, 32, data width
DEPTH, 8, FIFO entries (power of 2, >=2)
INDEX_W, 4, cache set index bits
OFFSET_W, 2, word offset bits; tag width TAG_W = ADDR_W-INDEX_W-OFFSET_W (6)
CNT_W, 16, statistics counter width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept
cmd_op  in  2  00 NOP, 01 READ, 10 WRITE, 11 FLUSH
cmd_addr  in  ADDR_W  byte/word address
cmd_data  in  DATA_W  write data (ignored for READ/NOP/FLUSH)
cache_req  out  1  request to cache, held until ack
cache_op  out  2  op of current request (01/10/11)
cache_tag  out  TAG_W  addr[ADDR_W-1:INDEX_W+OFFSET_W]
cache_index  out  INDEX_W  addr[INDEX_W+OFFSET_W-1:OFFSET_W]
cache_offset  out  OFFSET_W  addr[OFFSET_W-1:0]
cache_wdata  out  DATA_W  write data
cache_ack  in  1  cache completed current request
cache_rdata  in  DATA_W  read data, valid with cache_ack on READ
rsp_valid  out  1  one-cycle read response pulse
rsp_data  out  DATA_W  read data
rsp_addr  out  ADDR_W  address of the read
rd_count, wr_count, fl_count, nop_count  out  CNT_W each  completed-op counters
busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (async assert, sync release): FIFO empty, FSM IDLE, all outputs 0 except cmd_ready=1. Reset mid-transaction abandons the request; cache_req drops immediately.
- Push: cmd_valid & cmd_ready at a rising edge writes {op,addr,data} at the write pointer.
- cmd_ready = (count != DEPTH), from registered count. A push is refused when the FIFO is full, even if a pop happens in the same cycle.
- Pointers wrap modulo DEPTH. count is log2(DEPTH)+1 bits. Simultaneous push and pop leaves count unchanged.
- FSM states are IDLE, ISSUE and RESP.
- IDLE with FIFO non-empty: pop the head at the edge.
  - Op NOP: increment nop_count, stay IDLE. A NOP takes one cycle and is never issued.
  - Any other op: load the issue registers (op, addr, data) and go to ISSUE.
- ISSUE: cache_req=1. cache_op/tag/index/offset/wdata are driven from the issue registers and are stable until ack. On an edge with cache_ack=1:
  - READ: capture cache_rdata and addr, increment rd_count, go to RESP.
  - WRITE: increment wr_count, go to IDLE.
  - FLUSH: increment fl_count, go to IDLE.
  - cache_ack is ignored in IDLE and RESP.
- RESP: rsp_valid=1 for exactly one cycle with rsp_data/rsp_addr. The response has no backpressure. Next state is IDLE.
- Outside ISSUE, cache_req=0 and the cache_* fields hold their last values.
- Latency, command pushed into an empty FIFO while IDLE at edge T:
  - cache_req is high in the cycle after T+1.
  - With ack at the first ISSUE edge, a READ gives rsp_valid in the cycle after T+2.
  - Minimum issued-command spacing is 2 cycles for WRITE/FLUSH and 3 cycles for READ.
- Counters wrap at 2^CNT_W.
- Commands issue to the cache in FIFO order. Only one request is outstanding at a time.

Test Plan:
- Reset: drive rst_n=0 mid-ISSUE with cache_req=1 -> cache_req=0, cmd_ready=1, all counters 0, busy=0 immediately, without waiting for a clock edge.
- WRITE: op=10, addr=0x0A5, data=7, ack one cycle after req -> cache_tag=0x02, index=0x9, offset=0x1, wdata=7. Then wr_count=1, rsp_valid never asserts.
- READ with slow cache: op=01, addr=0x0A5, ack after 3 req cycles with rdata=0x1234 -> req held for 3 cycles with stable fields. Then a single rsp_valid pulse with rsp_data=0x1234, rsp_addr=0x0A5, and rd_count=1.
- Full FIFO: hold cache_ack=0 and push 10 WRITEs back-to-back -> 9 accepted (1 in ISSUE plus 8 buffered), after which cmd_ready=0. Release ack -> all 9 issued in push order, wr_count=9.
- NOP/FLUSH mix: push NOP, FLUSH 0x3FF, NOP -> exactly one cache_req with cache_op=11, tag=0x0F, index=0xF, offset=0x3. Then nop_count=2, fl_count=1.
- Push while popping: at count=DEPTH, push and pop in the same cycle -> the push is not accepted and count drops to 7.
